// File: rtl/divider_seq_if.sv
// Handshake and operand bundle for the sequential 32-bit RV32 divider.
interface divider_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, dividend, divisor, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, dividend, divisor, flush,
        output busy, done, result
    );
endinterface

// File: rtl/divider_seq.sv
// Sequential restoring radix-2 divider for DIV/DIVU/REM/REMU (32-bit).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module divider_seq (
    input  logic         clk,
    input  logic         rst,
    divider_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

    state_t      state_reg;
    logic        sel_rem_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        div_zero_reg;
    logic [31:0] q_reg;
    logic [31:0] rem_reg;
    logic [31:0] div_mag_reg;
    logic [4:0]  count_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] result_reg;

    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        b_zero;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [31:0] fixed_q;
    logic [31:0] fixed_r;

    // Op encoding: bit 0 set means unsigned, bit 1 set means remainder.
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.dividend[31];
    assign b_neg     = signed_op & bus.divisor[31];
    assign a_mag     = a_neg ? (32'd0 - bus.dividend) : bus.dividend;
    assign b_mag     = b_neg ? (32'd0 - bus.divisor) : bus.divisor;
    assign b_zero    = (bus.divisor == 32'd0);

    // The remainder is always below the divisor, so the 33-bit shifted value
    // minus the divisor fits back into 32 bits when the subtraction succeeds.
    assign rem_shift = {rem_reg, q_reg[31]};
    assign rem_ge    = (rem_shift >= {1'b0, div_mag_reg});
    assign rem_sub   = rem_shift[31:0] - div_mag_reg;

    assign fixed_q = neg_q_reg ? (32'd0 - q_reg) : q_reg;
    assign fixed_r = neg_r_reg ? (32'd0 - rem_reg) : rem_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_rem_reg  <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            q_reg        <= 32'd0;
            rem_reg      <= 32'd0;
            div_mag_reg  <= 32'd0;
            count_reg    <= 5'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= 32'd0;
        end else if (bus.flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            count_reg <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sel_rem_reg  <= bus.op[1];
                        neg_q_reg    <= (a_neg ^ b_neg) & ~b_zero;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= b_zero;
                        div_mag_reg  <= b_mag;
                        count_reg    <= 5'd0;
                        busy_reg     <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                        // Load the divide-by-zero answer directly so FIXUP is shared.
                        if (b_zero) begin
                            q_reg     <= 32'hFFFF_FFFF;
                            rem_reg   <= a_mag;
                            state_reg <= FIXUP;
                        end else begin
                            q_reg     <= a_mag;
                            rem_reg   <= 32'd0;
                            state_reg <= DIVIDE;
                        end
`else
                        q_reg     <= a_mag;
                        rem_reg   <= 32'd0;
                        state_reg <= DIVIDE;
`endif
                    end
                end
                DIVIDE: begin
                    rem_reg   <= rem_ge ? rem_sub : rem_shift[31:0];
                    q_reg     <= {q_reg[30:0], rem_ge};
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31) begin
                        state_reg <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_reg <= sel_rem_reg ? fixed_r : fixed_q;
                    done_reg   <= 1'b1;
                    busy_reg   <= 1'b0;
                    state_reg  <= DONE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: vector table through a scoreboard plus flush/reset/DONE-cycle sequences.
module tb_divider_seq;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 34;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic clk;
    logic rst;
    divider_seq_if bus();

    divider_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    vec_t vecs[16];
    logic [31:0] last_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for done; cyc counts edges since the start was sampled.
    task automatic wait_done(input int start_cyc, output int cyc);
        cyc = start_cyc;
        while (bus.done !== 1'b1 && cyc < 80) begin
            step();
            cyc++;
        end
        if (bus.done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for done after %0d cycles", cyc);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int lat);
        exp_t e;
        exp_t got;
        int   cyc;
        e.res = exp_res;
        e.lat = lat;
        sb.push_back(e);
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        wait_done(1, cyc);
        got = sb.pop_front();
        check("result", bus.result, got.res);
        check("latency", cyc, got.lat);
        check("busy_in_done", {31'd0, bus.busy}, 32'd0);
        $display("op=%0d a=%h b=%h result=%h cycles=%0d", op, a, b, bus.result, cyc);
        last_exp = got.res;
        step();
        check("done_single_pulse", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int   cyc;
        logic saw_done;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
        vecs[4]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[5]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000};
        vecs[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
        vecs[8]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
        vecs[9]  = '{OP_REMU, 32'd12345,      32'd0,          32'd12345};
        vecs[10] = '{OP_REMU, 32'hFFFF_FFFF,  32'd10,         32'd5};
        vecs[11] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD};
        vecs[12] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
        vecs[13] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
        vecs[14] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
        vecs[15] = '{OP_DIVU, 32'd1000000,    32'd1000,       32'd1000};

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;
        last_exp     = 32'd0;
        step();
        step();
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;

        // First start immediately after reset release must be accepted.
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                  (vecs[i].b == 32'd0) ? ZLAT : 34);
        end

        // Start raised in the DONE cycle is ignored, accepted one cycle later.
        bus.op = OP_DIVU; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(1, cyc);
        check("done_seq_result", bus.result, 32'd14);
        bus.op = OP_DIVU; bus.dividend = 32'd50; bus.divisor = 32'd5; bus.start = 1'b1;
        step();
        check("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
        step();
        bus.start = 1'b0;
        check("start_after_done_accepted", {31'd0, bus.busy}, 32'd1);
        wait_done(1, cyc);
        check("after_done_result", bus.result, 32'd10);
        check("after_done_latency", cyc, 34);
        $display("op=1 a=00000032 b=00000005 result=%h cycles=%0d", bus.result, cyc);
        last_exp = 32'd10;
        step();

        // Flush at cycle 10 cancels the operation.
        saw_done = 1'b0;
        bus.op = OP_DIVU; bus.dividend = 32'd9; bus.divisor = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            step();
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_result_held", bus.result, last_exp);
        check("flush_no_done", {31'd0, saw_done | bus.done}, 32'd0);
        $display("flush at cycle 10: busy=%b result=%h", bus.busy, bus.result);
        do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // Flush wins over a simultaneous start.
        bus.op = OP_DIVU; bus.dividend = 32'd8; bus.divisor = 32'd2;
        bus.start = 1'b1; bus.flush = 1'b1;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_beats_start", {31'd0, bus.busy}, 32'd0);
        step();
        check("flush_beats_start_idle", {30'd0, bus.busy, bus.done}, 32'd0);
        $display("start+flush together: busy=%b", bus.busy);

        // Asynchronous reset mid-operation.
        bus.op = OP_DIV; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("async_rst_done", {31'd0, bus.done}, 32'd0);
        check("async_rst_result", bus.result, 32'd0);
        #3 rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_rst", {31'd0, saw_done}, 32'd0);
        $display("reset at cycle 15: result=%h done_seen=%b", bus.result, saw_done);
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);

        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
